// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 host transmitter types and constants.
// State encoding, frame constants, timing defaults and parity helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_DATA,
    ST_WAITIDLE
  } state_t;

  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic LINE_IDLE  = 1'b1;

  localparam int INHIBIT_US = 100;
  localparam int TIMEOUT_US = 15000;
  localparam int TO_W       = 19;

  function automatic logic odd_par(
    input logic [7:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer for the PS/2 clock and data lines.
// Flops reset to the idle-high level; clock falling edge is flagged.
module ps2_line_sync
  import ps2_host_tx_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_clk,
  input  logic i_dat,
  output logic o_clk,
  output logic o_dat,
  output logic o_clk_fe
);

  logic r_clk_meta;
  logic r_clk_sync;
  logic r_clk_prev;
  logic r_dat_meta;
  logic r_dat_sync;

  // Synchronize both lines and keep the previous clock sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_meta <= LINE_IDLE;
      r_clk_sync <= LINE_IDLE;
      r_clk_prev <= LINE_IDLE;
      r_dat_meta <= LINE_IDLE;
      r_dat_sync <= LINE_IDLE;
    end else begin
      r_clk_meta <= i_clk;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= i_dat;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign o_clk    = r_clk_sync;
  assign o_dat    = r_dat_sync;
  assign o_clk_fe = r_clk_prev & ~r_clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter, open-drain OEs.
// Optional PS2_TX_RETRY_EN re-sends a NACKed/timed-out byte.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_HZ         = 25000000,
  parameter int INHIBIT_CYCLES = (CLK_HZ / 1000000) * INHIBIT_US,
  parameter int TIMEOUT_CYCLES = (CLK_HZ / 1000000) * TIMEOUT_US
`ifdef PS2_TX_RETRY_EN
  ,
  parameter int MAX_RETRY      = 2
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       to_err,
  input  logic       ps2clk_in,
  input  logic       ps2dat_in,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  logic w_clk_sync;
  logic w_dat_sync;
  logic w_clk_fe;

  ps2_line_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clk    (ps2clk_in),
    .i_dat    (ps2dat_in),
    .o_clk    (w_clk_sync),
    .o_dat    (w_dat_sync),
    .o_clk_fe (w_clk_fe)
  );

  state_t            r_state;
  logic [8:0]        r_shift;
  logic [3:0]        r_bitcnt;
  logic [INH_W-1:0]  r_inh_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_clk_oe;
  logic              r_dat_oe;

  state_t            w_state_nxt;
  logic [8:0]        w_shift_nxt;
  logic [3:0]        w_bitcnt_nxt;
  logic [INH_W-1:0]  w_inh_nxt;
  logic [TO_W-1:0]   w_to_nxt;
  logic              w_clk_oe_nxt;
  logic              w_dat_oe_nxt;
  logic              w_to_hit;
  logic              w_nack;
  logic              w_tmo;
  logic              w_done;
  logic              w_ack_err;
  logic              w_to_err;

`ifdef PS2_TX_RETRY_EN
  logic [7:0]        r_byte;
  logic [1:0]        r_retry;
  logic [7:0]        w_byte_nxt;
  logic [1:0]        w_retry_nxt;
`endif

  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

  // Next-state, datapath updates and single-cycle result pulses.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_inh_nxt    = r_inh_cnt;
    w_to_nxt     = r_to_cnt;
    w_clk_oe_nxt = r_clk_oe;
    w_dat_oe_nxt = r_dat_oe;
    w_nack       = 1'b0;
    w_tmo        = 1'b0;
    w_done       = 1'b0;
    w_ack_err    = 1'b0;
    w_to_err     = 1'b0;
`ifdef PS2_TX_RETRY_EN
    w_byte_nxt   = r_byte;
    w_retry_nxt  = r_retry;
`endif

    unique case (r_state)
      ST_IDLE: begin
        if (tx_valid) begin
          w_shift_nxt  = {odd_par(tx_data), tx_data};
          w_bitcnt_nxt = '0;
          w_inh_nxt    = '0;
          w_clk_oe_nxt = 1'b1;
          w_dat_oe_nxt = 1'b0;
          w_state_nxt  = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          w_byte_nxt   = tx_data;
          w_retry_nxt  = '0;
`endif
        end
      end
      ST_INHIBIT: begin
        w_inh_nxt = r_inh_cnt + INH_W'(1);
        if (int'(r_inh_cnt) + 2 >= INHIBIT_CYCLES)
          w_dat_oe_nxt = ~START_BIT;
        if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          w_clk_oe_nxt = 1'b0;
          w_to_nxt     = '0;
          w_state_nxt  = ST_RTS;
        end
      end
      ST_RTS: begin
        w_to_nxt = r_to_cnt + TO_W'(1);
        if (w_clk_fe) begin
          w_to_nxt     = '0;
          w_dat_oe_nxt = ~r_shift[0];
          w_shift_nxt  = {STOP_BIT, r_shift[8:1]};
          w_bitcnt_nxt = 4'd1;
          w_state_nxt  = ST_DATA;
        end else if (w_to_hit) begin
          w_tmo = 1'b1;
        end
      end
      ST_DATA: begin
        w_to_nxt = r_to_cnt + TO_W'(1);
        if (w_clk_fe) begin
          w_to_nxt     = '0;
          w_bitcnt_nxt = r_bitcnt + 4'd1;
          if (r_bitcnt <= 4'd8) begin
            w_dat_oe_nxt = ~r_shift[0];
            w_shift_nxt  = {STOP_BIT, r_shift[8:1]};
          end else if (r_bitcnt == 4'd9) begin
            w_dat_oe_nxt = ~STOP_BIT;
          end else if (!w_dat_sync) begin
            w_state_nxt = ST_WAITIDLE;
          end else begin
            w_nack = 1'b1;
          end
        end else if (w_to_hit) begin
          w_tmo = 1'b1;
        end
      end
      ST_WAITIDLE: begin
        w_to_nxt = r_to_cnt + TO_W'(1);
        if (w_clk_fe)
          w_to_nxt = '0;
        if (w_clk_sync && w_dat_sync) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_to_hit) begin
          w_tmo = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_nack || w_tmo) begin
      w_clk_oe_nxt = 1'b0;
      w_dat_oe_nxt = 1'b0;
      w_state_nxt  = ST_IDLE;
`ifdef PS2_TX_RETRY_EN
      if (r_retry < 2'(MAX_RETRY)) begin
        w_retry_nxt  = r_retry + 2'd1;
        w_shift_nxt  = {odd_par(r_byte), r_byte};
        w_bitcnt_nxt = '0;
        w_inh_nxt    = '0;
        w_clk_oe_nxt = 1'b1;
        w_state_nxt  = ST_INHIBIT;
      end else begin
        w_ack_err = w_nack;
        w_to_err  = w_tmo;
      end
`else
      w_ack_err = w_nack;
      w_to_err  = w_tmo;
`endif
    end
  end

  // State and datapath registers; reset releases both lines at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      r_byte    <= '0;
      r_retry   <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_inh_cnt <= w_inh_nxt;
      r_to_cnt  <= w_to_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_dat_oe  <= w_dat_oe_nxt;
`ifdef PS2_TX_RETRY_EN
      r_byte    <= w_byte_nxt;
      r_retry   <= w_retry_nxt;
`endif
    end
  end

  assign tx_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = w_done;
  assign ack_err   = w_ack_err;
  assign to_err    = w_to_err;
  assign ps2clk_oe = r_clk_oe;
  assign ps2dat_oe = r_dat_oe;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter for the keyboard port on usb_fpga_dp (clock) and usb_fpga_dn (data); the other direction of the existing keyboard receiver in sys.
- Sends one command byte per request (LED set 0xED, reset 0xFF, typematic 0xF3, ...) using the inhibit / request-to-send / device-clocked shift / ACK sequence.
- Drives the lines open-drain through output enables; a high output enable pulls the line low.
- Runs on pll_25mhz and sits beside the receiver in the top level.

Parameters:
- CLK_HZ, 25000000: system clock frequency in Hz.
- INHIBIT_CYCLES, 2500: cycles the clock line is held low before RTS (100 us at 25 MHz).
- TIMEOUT_CYCLES, 375000: maximum cycles between consecutive device clock falling edges, counted from RTS (15 ms).
- MAX_RETRY, 2: retry count, used only with PS2_TX_RETRY_EN.

Ports:
- clk, input, 1: system clock (pll_25mhz).
- reset_n, input, 1: asynchronous active-low reset.
- tx_data, input, 8: byte to send.
- tx_valid, input, 1: request; accepted only when tx_valid and tx_ready are both high.
- tx_ready, output, 1: high in IDLE only.
- busy, output, 1: high from acceptance through DONE; the receiver ignores the lines while busy is high.
- done, output, 1: one-cycle pulse when the device ACKed.
- ack_err, output, 1: one-cycle pulse when the 11th edge sees data high (NACK).
- to_err, output, 1: one-cycle pulse when the timeout expires.
- ps2clk_in, input, 1: raw clock line, asynchronous.
- ps2dat_in, input, 1: raw data line, asynchronous.
- ps2clk_oe, output, 1: 1 = pull the clock line low.
- ps2dat_oe, output, 1: 1 = pull the data line low.

Behaviour:
- Line inputs pass through a 2-flop synchronizer. A falling edge (fe) is previous-sync 1 and current-sync 0, giving 2-3 cycles of latency.
- Reset: state IDLE; all outputs 0 except tx_ready = 1; counters 0; shift register 0; lines released immediately, asynchronously.
- IDLE:
  - tx_ready = 1.
  - On accept: latch {odd_parity(tx_data), tx_data} into a 9-bit shift register; bitcnt = 0; then INHIBIT.
  - parity = ~^tx_data.
- INHIBIT:
  - ps2clk_oe = 1 for exactly INHIBIT_CYCLES cycles.
  - On the last cycle set ps2dat_oe = 1 (start bit 0), then RTS.
- RTS:
  - ps2clk_oe = 0, ps2dat_oe held at 1.
  - Timeout counter cleared on entry.
  - On fe: ps2dat_oe = ~shift[0], shift right, bitcnt = 1, then DATA.
- DATA, on each fe:
  - bitcnt 1..8: drive the next bit (data bits 1..7, then parity).
  - bitcnt 9: release the data line (stop bit = 1).
  - bitcnt 10: sample data_sync; 0 goes to WAITIDLE, 1 pulses ack_err and goes to IDLE.
  - Bits are LSB first and change only on fe.
- WAITIDLE:
  - Waits for clk_sync = 1 and dat_sync = 1, then pulses done and goes to IDLE.
  - Timeout applies here too.
- Timeout:
  - 19-bit counter, cleared on each fe and on RTS entry, active in RTS, DATA and WAITIDLE.
  - Reaching TIMEOUT_CYCLES releases both lines, pulses to_err, and returns to IDLE.
- tx_ready returns high in the cycle after any pulse; there is no back-to-back acceptance in the pulse cycle.
- tx_valid while busy is ignored; no queueing.
- A device fe during INHIBIT is ignored.
- Reset mid-frame: lines release immediately and no pulse is emitted.

Optional Feature:
- PS2_TX_RETRY_EN defined:
  - ack_err and to_err conditions restart from INHIBIT with the latched byte, up to MAX_RETRY times.
  - The error pulse is emitted only after the final failed attempt.
  - A 2-bit retry counter is cleared on accept.
- Undefined: a single attempt; the error pulse fires immediately; no retry counter logic.

Decomposition:
- Shared header ps2_defs.vh holds:
  - state encodings IDLE, INHIBIT, RTS, DATA, WAITIDLE;
  - frame constants: 11 bits, start = 0, stop = 1, odd parity;
  - PS/2 timing defaults in us.
- Sub-module ps2_line_sync (2-flop synchronizer plus falling-edge detector for clock and data), reused by the receiver.

Test Plan:
- Send 0xED with the device model clocking at a 2000-cycle period:
  - ps2clk_oe low for exactly 2500 cycles;
  - ps2dat_oe after fe 1..10 = 0,1,0,0,1,0,0,0,0,0 (data bits 1,0,1,1,0,1,1,1; parity 1; stop released);
  - device ACK 0 on the 11th edge, then lines idle → done pulses once and tx_ready = 1.
- Send 0x01: parity 0, so ps2dat_oe = 1 during the parity bit; send 0x00: parity 1, so ps2dat_oe = 0.
- Device leaves data high at the ACK edge → ack_err for 1 cycle, no done, both oe = 0.
- Device never clocks after RTS → to_err exactly TIMEOUT_CYCLES cycles (±3 for sync) after RTS entry; lines released.
- Assert reset_n low after fe 5 of a frame → ps2clk_oe = ps2dat_oe = 0 asynchronously; tx_ready = 1 after release.
- With PS2_TX_RETRY_EN, device NACKs twice then ACKs → three INHIBIT phases and one done; device NACKs three times → one ack_err.
